rw_mem_engine: RTL

Synthesizable memory command engine that consumes read/write commands from the `rw_cmd` pull server and produces responses for the `rw_rsp` push server. It replaces the behavioural processing loop in the emulation top with a clean valid/ready FSM. It holds a 2^ADDR_WIDTH × DATA_WIDTH word memory, cleared in hardware after reset, and adds out-of-range detection and access counters for host-side debug.

---
 rtl/rw_mem_engine.sv | 105 ++++++++++
 1 files changed

// File: rtl/rw_mem_engine.sv
// Read/write memory command engine: one outstanding command, valid/ready on both sides.
// Memory is zeroed by a hardware walk after every reset; debug counters and a sticky range flag.
module rw_mem_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      cmd_rdy,
  input  logic                      cmd_vld,
  input  logic [3*DATA_WIDTH-1:0]   cmd,
  input  logic                      rsp_rdy,
  output logic                      rsp_vld,
  output logic [DATA_WIDTH-1:0]     rsp,
  output logic                      oor_err,
  output logic [31:0]               num_rd,
  output logic [31:0]               num_wr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_RESP
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-1:0]   rwb;
  logic [DATA_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    is_read;
  logic                    in_range;
  logic                    accept;

  assign rwb      = cmd[0 +: DATA_WIDTH];
  assign address  = cmd[DATA_WIDTH +: DATA_WIDTH];
  assign wdata    = cmd[2*DATA_WIDTH +: DATA_WIDTH];
  assign idx      = address[ADDR_WIDTH-1:0];
  assign is_read  = |rwb;
  assign in_range = (address[DATA_WIDTH-1:ADDR_WIDTH] == '0);
  assign accept   = (state_q == S_IDLE) && cmd_vld;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (&clr_ptr) state_d = S_IDLE;
      S_IDLE:  if (cmd_vld)  state_d = S_RESP;
      S_RESP:  if (rsp_rdy)  state_d = S_IDLE;
      default:               state_d = S_CLEAR;
    endcase
  end

  // Handshake flags are pure decodes of the state register, so no input reaches them combinationally.
  always_comb begin
    cmd_rdy = (state_q == S_IDLE);
    rsp_vld = (state_q == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    clr_ptr <= '0;
    else if (state_q == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
  end

  // NOTE: the array has no reset branch; the CLEAR walk zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)
      mem[clr_ptr] <= '0;
    else if (accept && !is_read && in_range)
      mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp     <= '0;
      oor_err <= 1'b0;
      num_rd  <= '0;
      num_wr  <= '0;
    end else if (accept) begin
      if (!in_range) begin
        rsp     <= '1;
        oor_err <= 1'b1;
      end else if (is_read) begin
        rsp <= mem[idx];
      end else begin
        rsp <= '0;
      end
      if (is_read) num_rd <= num_rd + 32'd1;
      else         num_wr <= num_wr + 32'd1;
    end
  end

endmodule
